// File: rtl/reflet_reset_ctrl.sv
// reflet_reset_ctrl: system reset sequencer.
// Combines the bootstrap pulse (por), a synchronized and debounced reset
// button and a software reset request into one registered active-low reset.
// The output asserts immediately on the board reset. It is released
// synchronously once all requests have stayed clear for the hold time.
// Optional feature macro: REFLET_RESET_CAUSE_EN adds a sticky reset-cause
// register {sw, button, por}. Without the macro, cause reads as zero.
module reflet_reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       por,
    input  logic       button_n,
    input  logic       sw_reset,
    input  logic       cause_clr,
    output logic       rst_n_out,
    output logic [2:0] cause
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   sync_level;
    logic                   db_level_reg;
    logic                   db_level_next;
    logic [DB_W-1:0]        db_cnt_reg;
    logic [DB_W-1:0]        db_cnt_next;
    logic                   btn_req;
    logic                   req;
    state_t                 state_reg;
    state_t                 state_next;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic [HOLD_W-1:0]      hold_cnt_next;
    logic                   rst_n_next;

    // Synchronizer chain: stage 0 samples the raw pin, each later stage
    // samples its predecessor.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign sync_next[gi] = button_n;
            end else begin : g_tail
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign sync_level = sync_reg[SYNC_STAGES-1];

    // Synchronizer registers reset to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    // Debounce: the accepted level follows the synchronized level only after
    // DEBOUNCE_CYCLES consecutive differing samples. Any agreement restarts the count.
    always_comb begin
        db_level_next = db_level_reg;
        db_cnt_next   = '0;
        if (sync_level != db_level_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                db_level_next = sync_level;
            end else begin
                db_cnt_next = db_cnt_reg + DB_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_level_reg <= 1'b1;
            db_cnt_reg   <= '0;
        end else begin
            db_level_reg <= db_level_next;
            db_cnt_reg   <= db_cnt_next;
        end
    end

    assign btn_req = ~db_level_reg;
    assign req     = por | btn_req | sw_reset;

    // Sequencer: any request returns to ASSERT. Release needs one clear
    // cycle in ASSERT plus HOLD_CYCLES clear cycles in HOLD.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_ASSERT: begin
                if (!req) begin
                    state_next    = ST_HOLD;
                    hold_cnt_next = '0;
                end
            end
            ST_HOLD: begin
                if (req) begin
                    state_next = ST_ASSERT;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (req) begin
                    state_next = ST_ASSERT;
                end
            end
            default: begin
                state_next = ST_ASSERT;
            end
        endcase
        rst_n_next = (state_next == ST_RUN);
    end

    // State, hold counter and the registered reset output share one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_ASSERT;
            hold_cnt_reg <= '0;
            rst_n_out    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            rst_n_out    <= rst_n_next;
        end
    end

`ifdef REFLET_RESET_CAUSE_EN
    logic [2:0] cause_reg;
    logic [2:0] cause_next;

    // Sticky cause flags. A set in the same cycle as a clear takes priority.
    // The system reset output does not clear these flags.
    always_comb begin
        cause_next = cause_clr ? 3'b000 : cause_reg;
        cause_next = cause_next | {sw_reset, btn_req, por};
    end

    // Cause register is cleared only by the board reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_reg <= 3'b000;
        end else begin
            cause_reg <= cause_next;
        end
    end

    assign cause = cause_reg;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = cause_clr;
    assign cause            = 3'b000;
`endif

endmodule

// File: tb/tb_reflet_reset_ctrl.sv
// Self-checking bench for reflet_reset_ctrl.
// Reference model: the output is released once req has been sampled low on
// more than HOLD_CYCLES consecutive edges. The button is a delayed sample
// history. A level is accepted after DEBOUNCE_CYCLES consecutive
// disagreeing samples.
module tb_reflet_reset_ctrl;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 16;
    localparam int HOLD_CYCLES     = 8;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       por       = 1'b0;
    logic       button_n  = 1'b1;
    logic       sw_reset  = 1'b0;
    logic       cause_clr = 1'b0;
    logic       rst_n_out;
    logic [2:0] cause;

    int tests = 0;
    int fails = 0;

    reflet_reset_ctrl #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .por      (por),
        .button_n (button_n),
        .sw_reset (sw_reset),
        .cause_clr(cause_clr),
        .rst_n_out(rst_n_out),
        .cause    (cause)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit       m_hist [SYNC_STAGES];
    bit       m_deb;
    int       m_streak;
    int       m_quiet;
    bit [2:0] m_cause;

    function automatic bit exp_rst();
        return (m_quiet > HOLD_CYCLES);
    endfunction

    function automatic bit [2:0] exp_cause();
`ifdef REFLET_RESET_CAUSE_EN
        return m_cause;
`else
        return 3'b000;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b1;
        m_deb    = 1'b1;
        m_streak = 0;
        m_quiet  = 0;
        m_cause  = 3'b000;
    endtask

    task automatic model_edge();
        bit btn_req;
        bit req;
        bit s;
        btn_req = !m_deb;
        req     = por | btn_req | sw_reset;
        if (req) m_quiet = 0;
        else if (m_quiet < 1000) m_quiet++;
        if (cause_clr) m_cause = 3'b000;
        m_cause = m_cause | {sw_reset, btn_req, por};
        s = m_hist[SYNC_STAGES-1];
        if (s != m_deb) begin
            m_streak++;
            if (m_streak == DEBOUNCE_CYCLES) begin
                m_deb    = s;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = button_n;
    endtask

    // One clock: the model follows the rising edge, and the bench then waits
    // for the falling edge where outputs are compared and inputs change.
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({rst_n_out, cause} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async: rst_n_out/cause got %b/%b expected 0/000", rst_n_out, cause);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if ({rst_n_out, cause} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_hold: rst_n_out/cause got %b/%b expected 0/000", rst_n_out, cause);
            end
        end
        reset = 1'b1;
        por   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                fails++;
                $display("FAIL por_phase: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
            end
        end
        por = 1'b0;
        n = 0;
        while (rst_n_out !== 1'b1 && n < 40) begin
            step();
            n++;
            tests++;
            if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                fails++;
                $display("FAIL por_release: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
            end
        end
        tests++;
        if (n != HOLD_CYCLES + 1) begin
            fails++;
            $display("FAIL por_latency: rise after %0d edges expected %0d", n, HOLD_CYCLES + 1);
        end
`ifdef REFLET_RESET_CAUSE_EN
        tests++;
        if (cause !== 3'b001) begin
            fails++;
            $display("FAIL por_cause: cause got %b expected 001", cause);
        end
`endif
    endtask

    task automatic test_sw_pulse();
        int n;
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        tests++;
        if ({rst_n_out, cause} !== {exp_rst(), exp_cause()} || rst_n_out !== 1'b0) begin
            fails++;
            $display("FAIL sw_fall: rst_n_out/cause got %b/%b expected 0/%b", rst_n_out, cause, exp_cause());
        end
        n = 0;
        while (rst_n_out === 1'b0 && n < 40) begin
            n++;
            step();
            tests++;
            if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                fails++;
                $display("FAIL sw_hold: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
            end
        end
        tests++;
        if (n != HOLD_CYCLES + 1) begin
            fails++;
            $display("FAIL sw_low_len: low for %0d cycles expected %0d", n, HOLD_CYCLES + 1);
        end
`ifdef REFLET_RESET_CAUSE_EN
        tests++;
        if (cause[2] !== 1'b1) begin
            fails++;
            $display("FAIL sw_cause: cause got %b expected bit2 set", cause);
        end
`endif
    endtask

    task automatic test_glitch();
        int low_seen;
        int len;
        low_seen = 0;
        for (int g = 0; g < 3; g++) begin
            len = (g == 0) ? 10 : $urandom_range(1, DEBOUNCE_CYCLES - 1);
            button_n = 1'b0;
            for (int i = 0; i < len + 30; i++) begin
                if (i == len) button_n = 1'b1;
                step();
                if (rst_n_out !== 1'b1) low_seen++;
                tests++;
                if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                    fails++;
                    $display("FAIL glitch: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
                end
            end
        end
        tests++;
        if (low_seen != 0) begin
            fails++;
            $display("FAIL glitch_reached: rst_n_out low %0d cycles expected 0", low_seen);
        end
    endtask

    task automatic test_bounce();
        int n;
        int fall_at;
        // three short bounces before the final press
        for (int b = 0; b < 3; b++) begin
            button_n = 1'b0;
            repeat ($urandom_range(1, 5)) step();
            button_n = 1'b1;
            repeat ($urandom_range(1, 5)) step();
        end
        button_n = 1'b0;
        fall_at = -1;
        for (n = 1; n <= 40; n++) begin
            step();
            if (fall_at < 0 && rst_n_out === 1'b0) fall_at = n;
            tests++;
            if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                fails++;
                $display("FAIL bounce_press: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
            end
        end
        // the capturing edge counts as edge 1, so the fall is 2+16 edges later
        tests++;
        if (fall_at != SYNC_STAGES + DEBOUNCE_CYCLES + 1) begin
            fails++;
            $display("FAIL bounce_fall: fell at edge %0d expected %0d", fall_at, SYNC_STAGES + DEBOUNCE_CYCLES + 1);
        end
        button_n = 1'b1;
        n = 0;
        while (rst_n_out !== 1'b1 && n < 80) begin
            step();
            n++;
            tests++;
            if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                fails++;
                $display("FAIL bounce_release: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
            end
        end
        tests++;
        if (n != SYNC_STAGES + DEBOUNCE_CYCLES + HOLD_CYCLES + 1) begin
            fails++;
            $display("FAIL bounce_rise: rose at edge %0d expected %0d", n, SYNC_STAGES + DEBOUNCE_CYCLES + HOLD_CYCLES + 1);
        end
    endtask

    task automatic test_hold_restart();
        int n;
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        // one edge into HOLD, five more bring the hold count to 5
        repeat (6) step();
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        tests++;
        if (rst_n_out !== 1'b0) begin
            fails++;
            $display("FAIL hold_restart_low: rst_n_out got %b expected 0", rst_n_out);
        end
        n = 0;
        while (rst_n_out !== 1'b1 && n < 40) begin
            step();
            n++;
            tests++;
            if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                fails++;
                $display("FAIL hold_restart: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
            end
        end
        tests++;
        if (n != HOLD_CYCLES + 1) begin
            fails++;
            $display("FAIL hold_restart_len: rise after %0d edges expected %0d", n, HOLD_CYCLES + 1);
        end
    endtask

    task automatic test_random();
        int btn_left;
        btn_left = 0;
        for (int i = 0; i < 1500; i++) begin
            por       = ($urandom_range(0, 199) == 0);
            sw_reset  = ($urandom_range(0, 99) == 0);
            cause_clr = ($urandom_range(0, 19) == 0);
            if (btn_left == 0) begin
                button_n = ~button_n;
                btn_left = $urandom_range(1, 40);
            end
            btn_left--;
            step();
            tests++;
            if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
                fails++;
                $display("FAIL random cyc=%0d: rst_n_out/cause got %b/%b expected %b/%b", i, rst_n_out, cause, exp_rst(), exp_cause());
            end
        end
        por       = 1'b0;
        sw_reset  = 1'b0;
        cause_clr = 1'b0;
        button_n  = 1'b1;
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (rst_n_out !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (rst_n_out !== 1'b1) begin
            fails++;
            $display("FAIL async_reach_run: rst_n_out got %b expected 1", rst_n_out);
        end
        @(posedge clk);
        model_edge();
        #3 reset = 1'b0;
        #1;
        tests++;
        if ({rst_n_out, cause} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset: rst_n_out/cause got %b/%b expected 0/000", rst_n_out, cause);
        end
        model_reset();
        @(negedge clk);
        reset     = 1'b1;
        cause_clr = 1'b1;
        sw_reset  = 1'b1;
        step();
        cause_clr = 1'b0;
        sw_reset  = 1'b0;
        tests++;
        if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
            fails++;
            $display("FAIL set_vs_clr: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
        end
`ifdef REFLET_RESET_CAUSE_EN
        tests++;
        if (cause !== 3'b100) begin
            fails++;
            $display("FAIL set_wins: cause got %b expected 100", cause);
        end
`endif
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        tests++;
        if ({rst_n_out, cause} !== {exp_rst(), exp_cause()}) begin
            fails++;
            $display("FAIL cause_clear: rst_n_out/cause got %b/%b expected %b/%b", rst_n_out, cause, exp_rst(), exp_cause());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sw_pulse();
        test_glitch();
        test_bounce();
        test_hold_restart();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reflet_reset_ctrl.md
Name: reflet_reset_ctrl

Overview:
Reset sequencer sitting directly downstream of the power-on bootstrap pulse generator. Merges the bootstrap pulse, a debounced external reset button and a software reset request into one clean active-low system reset. That reset asserts asynchronously, is released synchronously to clk, and is stretched by a fixed hold time. Its output drives the reset input of the CPU and all peripherals.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on the raw button input (>= 2)
DEBOUNCE_CYCLES, 16, cycles a synchronized button level must be stable before it is accepted (>= 1)
HOLD_CYCLES, 8, cycles rst_n_out is held low after all reset requests clear (>= 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low board reset
por  input  1  active-high bootstrap pulse, synchronous to clk
button_n  input  1  raw external reset button, active-low, asynchronous, bouncy
sw_reset  input  1  active-high software reset request, synchronous to clk, may be a single-cycle pulse
cause_clr  input  1  active-high, clears the reset-cause register
rst_n_out  output  1  registered active-low system reset
cause  output  3  reset-cause flags {sw, button, por}

Behaviour:
- Interface fact: one clock, clk; reset is asynchronous and active-low, named reset.
- While reset is low:
  - state = ASSERT; rst_n_out = 0 immediately, with no clock needed.
  - Synchronizer flops = 1; debounced button level = 1 (released); debounce and hold counters = 0.
  - cause = 0.
- Button path:
  - button_n passes through SYNC_STAGES flops.
  - Debounce counter increments each cycle the synchronized level differs from the debounced level.
  - Counter clears on any cycle the two levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synchronized value and the counter clears.
  - btn_req = debounced level == 0.
- req = por | btn_req | sw_reset, evaluated each cycle.
- FSM, registered, 3 states:
  - ASSERT: rst_n_out = 0. req = 0 -> HOLD, hold counter = 0. Otherwise stay.
  - HOLD: rst_n_out = 0. req = 1 -> ASSERT. Otherwise hold counter += 1; at HOLD_CYCLES-1 -> RUN.
  - RUN: rst_n_out = 1. req = 1 -> ASSERT.
- rst_n_out is a flop updated on the same edge as the state: it goes to 1 on the edge entering RUN and to 0 on the edge leaving RUN.
- Latency:
  - rst_n_out rises on the (HOLD_CYCLES+1)-th rising edge that samples req = 0, provided req stays 0 throughout.
  - rst_n_out falls on the first edge that samples req = 1 in RUN.
- Boundaries:
  - A req pulse of any length, including 1 cycle, during HOLD restarts the full sequence from ASSERT.
  - A single-cycle sw_reset in RUN produces a full reset of at least HOLD_CYCLES+1 cycles.
  - Button glitches shorter than DEBOUNCE_CYCLES never reach req.
  - Reset asserted mid-sequence returns everything to reset values immediately.
  - Hold counter is sized ceil(log2(HOLD_CYCLES+1)) and never wraps.
  - Debounce counter is sized the same way from DEBOUNCE_CYCLES and never wraps.

Optional Feature:
REFLET_RESET_CAUSE_EN
- Defined:
  - cause is a sticky register; each bit is set on any cycle its source (sw_reset, btn_req, por) is sampled high.
  - cause_clr clears all bits; if set and clear occur in the same cycle, set wins for that bit.
  - cause is not affected by rst_n_out, so software can read the cause after the reset it caused.
- Not defined: cause is tied to 3'b000, cause_clr is ignored, no cause flops exist.

Test Plan:
- reset low 2 cycles, then high; por high 3 cycles then low; HOLD_CYCLES=8 -> rst_n_out 0 throughout, rises on 9th edge after por low. With feature: cause = 3'b001.
- In RUN, sw_reset single-cycle pulse -> rst_n_out 0 on next edge, stays 0 exactly 9 cycles, then 1. With feature: cause bit2 set.
- In RUN, button_n low for 10 cycles (DEBOUNCE_CYCLES=16) -> rst_n_out stays 1, cause unchanged.
- button_n low for 40 cycles with 3 bounce toggles at start -> rst_n_out falls 2+16 cycles after the last bounce. Rises 1+8 cycles after the debounced release, which follows 2+16 stable-high cycles.
- During HOLD (hold counter = 5), sw_reset pulse -> back to ASSERT; next release needs full 9 cycles, not 3.
- Reset pulled low while in RUN, asynchronous to clk -> rst_n_out 0 before the next clk edge, cause = 0. With feature: cause_clr and sw_reset in the same cycle -> bit2 = 1.
